// File: rtl/stopwatch_uart_pkg.sv
// Shared constants for the stopwatch UART command path: ASCII command bytes,
// decoder FSM state encoding and the byte-to-command mapping.
package stopwatch_uart_pkg;

    localparam logic [7:0] ASCII_M_UC  = 8'h4D;
    localparam logic [7:0] ASCII_M_LC  = 8'h6D;
    localparam logic [7:0] ASCII_A_UC  = 8'h41;
    localparam logic [7:0] ASCII_A_LC  = 8'h61;
    localparam logic [7:0] ASCII_R_UC  = 8'h52;
    localparam logic [7:0] ASCII_R_LC  = 8'h72;
    localparam logic [7:0] ASCII_C_UC  = 8'h43;
    localparam logic [7:0] ASCII_C_LC  = 8'h63;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DECODE = 2'b01,
        ST_ECHO   = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_SEL_M = 3'd1,
        CMD_SEL_A = 3'd2,
        CMD_RUN   = 3'd3,
        CMD_CLEAR = 3'd4
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        case (b)
            ASCII_M_UC, ASCII_M_LC: c = CMD_SEL_M;
            ASCII_A_UC, ASCII_A_LC: c = CMD_SEL_A;
            ASCII_R_UC, ASCII_R_LC: c = CMD_RUN;
            ASCII_C_UC, ASCII_C_LC: c = CMD_CLEAR;
            default:                c = CMD_NONE;
        endcase
        return c;
    endfunction

    // Recognised commands are echoed verbatim; anything else echoes '?'.
    function automatic logic [7:0] echo_byte(input logic [7:0] b);
        logic [7:0] e;
        if (decode_cmd(b) == CMD_NONE) begin
            e = ASCII_QMARK;
        end else begin
            e = b;
        end
        return e;
    endfunction

endpackage

// File: rtl/cmd_decoder_pulse_stretch.sv
// Stretches a single-cycle fire strobe into a PULSE_LEN-cycle pulse; a re-fire
// while active restarts the count from PULSE_LEN.
module pulse_stretch #(
    parameter int PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic pulse
);

    localparam logic [7:0] LEN_C = 8'(PULSE_LEN);

    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       pulse_r;

    // Remaining-cycle count: reload on fire, otherwise count down to zero.
    always_comb begin
        cnt_next_s = 8'd0;
        if (fire) begin
            cnt_next_s = LEN_C;
        end else if (cnt_r != 8'd0) begin
            cnt_next_s = cnt_r - 8'd1;
        end else begin
            cnt_next_s = 8'd0;
        end
    end

    // Counter and registered pulse output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= 8'd0;
            pulse_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            pulse_r <= (cnt_next_s != 8'd0);
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/cmd_decoder.sv
// UART command decoder: accepts one byte at a time, applies toggle/pulse
// commands and optionally echoes the byte (or '?') back to the transmitter.
module cmd_decoder #(
    parameter int PULSE_LEN = 4,
    parameter int ECHO_EN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic       o_sel_m,
    output logic       o_sel_a,
    output logic       o_run,
    output logic       o_clear,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] o_err_cnt
);

    import stopwatch_uart_pkg::*;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] byte_r;
    cmd_t       cmd_s;

    logic       latch_byte_s;
    logic       decode_s;
    logic       drop_s;
    logic       tx_start_next_s;

    logic       toggle_m_r;
    logic       toggle_a_r;
    logic       fire_run_r;
    logic       fire_clear_r;
    logic       sel_m_r;
    logic       sel_a_r;
    logic       tx_start_r;
    logic [7:0] tx_data_r;
    logic [7:0] err_cnt_r;

    assign cmd_s = decode_cmd(byte_r);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_next_s    = state_r;
        latch_byte_s    = 1'b0;
        decode_s        = 1'b0;
        drop_s          = 1'b0;
        tx_start_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_done) begin
                    latch_byte_s = 1'b1;
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECODE: begin
                decode_s = 1'b1;
                drop_s   = rx_done;
                if (ECHO_EN != 0) begin
                    state_next_s = ST_ECHO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ECHO: begin
                drop_s = rx_done;
                if (!tx_busy) begin
                    tx_start_next_s = 1'b1;
                    state_next_s    = ST_IDLE;
                end else begin
                    state_next_s = ST_ECHO;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Byte capture, decoded command strobes, echo byte and drop counter.
    // Strobes are registered in DECODE so outputs move one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_r       <= 8'h00;
            toggle_m_r   <= 1'b0;
            toggle_a_r   <= 1'b0;
            fire_run_r   <= 1'b0;
            fire_clear_r <= 1'b0;
            tx_data_r    <= 8'h00;
            tx_start_r   <= 1'b0;
            err_cnt_r    <= 8'h00;
        end else begin
            if (latch_byte_s) begin
                byte_r <= rx_data;
            end
            toggle_m_r   <= decode_s && (cmd_s == CMD_SEL_M);
            toggle_a_r   <= decode_s && (cmd_s == CMD_SEL_A);
            fire_run_r   <= decode_s && (cmd_s == CMD_RUN);
            fire_clear_r <= decode_s && (cmd_s == CMD_CLEAR);
            if (decode_s) begin
                tx_data_r <= echo_byte(byte_r);
            end
            tx_start_r <= tx_start_next_s;
            if (drop_s && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    // Mode/digit select levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_m_r <= 1'b0;
            sel_a_r <= 1'b0;
        end else begin
            if (toggle_m_r) begin
                sel_m_r <= ~sel_m_r;
            end
            if (toggle_a_r) begin
                sel_a_r <= ~sel_a_r;
            end
        end
    end

    pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_run_pulse (
        .clk   (clk),
        .rst   (rst),
        .fire  (fire_run_r),
        .pulse (o_run)
    );

    pulse_stretch #(.PULSE_LEN(PULSE_LEN)) u_clear_pulse (
        .clk   (clk),
        .rst   (rst),
        .fire  (fire_clear_r),
        .pulse (o_clear)
    );

    assign o_sel_m   = sel_m_r;
    assign o_sel_a   = sel_a_r;
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign o_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_cmd_decoder.sv
// Self-checking bench for cmd_decoder: directed scenarios plus random traffic,
// all outputs compared every cycle against an event-schedule reference model.
module tb_cmd_decoder;

    localparam int PLEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic       o_sel_m;
    logic       o_sel_a;
    logic       o_run;
    logic       o_clear;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] o_err_cnt;

    cmd_decoder #(.PULSE_LEN(PLEN), .ECHO_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_busy   (tx_busy),
        .o_sel_m   (o_sel_m),
        .o_sel_a   (o_sel_a),
        .o_run     (o_run),
        .o_clear   (o_clear),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .o_err_cnt (o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model state: a byte accepted at edge acc has its command
    // applied at acc+2 and is echoed at the first edge >= acc+2 with tx_busy low.
    bit         m_busy = 1'b0;
    int         m_acc  = 0;
    logic [7:0] m_byte = 8'h00;
    int         run_end = 0;
    int         clr_end = 0;
    bit         exp_sel_m = 1'b0;
    bit         exp_sel_a = 1'b0;
    bit         exp_tx_start = 1'b0;
    logic [7:0] exp_tx_data = 8'h00;
    int         exp_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        bit         was_busy;
        logic [7:0] lc;
        exp_tx_start = 1'b0;
        if (rst) begin
            m_busy      = 1'b0;
            exp_sel_m   = 1'b0;
            exp_sel_a   = 1'b0;
            run_end     = 0;
            clr_end     = 0;
            exp_tx_data = 8'h00;
            exp_err     = 0;
        end else begin
            was_busy = m_busy;
            if (rx_done) begin
                if (!was_busy) begin
                    m_byte = rx_data;
                    m_acc  = cyc;
                    m_busy = 1'b1;
                end else if (exp_err < 255) begin
                    exp_err++;
                end
            end
            if (was_busy) begin
                lc = m_byte | 8'h20;
                if (cyc == m_acc + 1) begin
                    if (lc == 8'h6D || lc == 8'h61 || lc == 8'h72 || lc == 8'h63) begin
                        exp_tx_data = m_byte;
                    end else begin
                        exp_tx_data = 8'h3F;
                    end
                end
                if (cyc == m_acc + 2) begin
                    if (lc == 8'h6D) exp_sel_m = ~exp_sel_m;
                    if (lc == 8'h61) exp_sel_a = ~exp_sel_a;
                    if (lc == 8'h72) run_end = cyc + PLEN;
                    if (lc == 8'h63) clr_end = cyc + PLEN;
                end
                if (cyc >= m_acc + 2 && !tx_busy) begin
                    exp_tx_start = 1'b1;
                    m_busy       = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [7:0] d, input logic busy);
        rst     = r;
        rx_done = rd;
        rx_data = d;
        tx_busy = busy;
        @(posedge clk);
        cyc++;
        #1;
        model_edge();
        check_eq("o_sel_m",   32'(o_sel_m),   32'(exp_sel_m));
        check_eq("o_sel_a",   32'(o_sel_a),   32'(exp_sel_a));
        check_eq("o_run",     32'(o_run),     32'(cyc < run_end));
        check_eq("o_clear",   32'(o_clear),   32'(cyc < clr_end));
        check_eq("tx_start",  32'(tx_start),  32'(exp_tx_start));
        check_eq("tx_data",   32'(tx_data),   32'(exp_tx_data));
        check_eq("o_err_cnt", 32'(o_err_cnt), 32'(exp_err));
    endtask

    task automatic idle(input int n, input logic busy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, busy);
    endtask

    logic [7:0] cmd_tbl [10] = '{8'h4D, 8'h6D, 8'h41, 8'h61, 8'h52,
                                 8'h72, 8'h43, 8'h63, 8'h5A, 8'h3F};

    initial begin
        logic busy_lvl;
        rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; tx_busy = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);

        // Mode toggle on then off, with echo.
        step(1'b0, 1'b1, 8'h4D, 1'b0); idle(4, 1'b0);
        step(1'b0, 1'b1, 8'h6D, 1'b0); idle(4, 1'b0);

        // Run pulse, then re-fire while still high.
        step(1'b0, 1'b1, 8'h52, 1'b0); idle(2, 1'b0);
        step(1'b0, 1'b1, 8'h72, 1'b0); idle(8, 1'b0);

        // Unrecognised byte.
        step(1'b0, 1'b1, 8'h5A, 1'b0); idle(4, 1'b0);

        // Echo held off by tx_busy with a dropped byte during the wait.
        step(1'b0, 1'b1, 8'h41, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, (i == 5), 8'h4D, 1'b1);
        idle(4, 1'b0);

        // Drop counter saturation.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h43, 1'b1);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'h52, 1'b1);
        idle(10, 1'b0);

        // Reset during echo after a clear command.
        step(1'b0, 1'b1, 8'h43, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b1);
        idle(6, 1'b0);

        // Random traffic.
        busy_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       rd;
            logic [7:0] d;
            if ($urandom_range(0, 7) == 0) busy_lvl = ~busy_lvl;
            r  = ($urandom_range(0, 399) == 0);
            rd = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) d = cmd_tbl[$urandom_range(0, 9)];
            else d = 8'($urandom);
            step(r, rd, d, busy_lvl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
